// File: rtl/jtframe_i2s_rx.sv
// I2S receiver: oversamples BCLK/LRCLK/DATA with clk and rebuilds MSB-aligned
// left/right samples; a watchdog drops lock when the bit clock stalls.
module jtframe_i2s_rx #(
   parameter int W    = 16,
   parameter int TOUT = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i2s_bclk,
   input  logic         i2s_lrclk,
   input  logic         i2s_data,
   output logic [W-1:0] snd_left,
   output logic [W-1:0] snd_right,
   output logic         sample,
   output logic         frame_err,
   output logic         locked
);

   localparam int             WDW     = (TOUT < 2) ? 1 : $clog2(TOUT + 1);
   localparam logic [WDW-1:0] TOUT_V  = WDW'(TOUT);
   localparam logic [WDW-1:0] TOUT_M1 = WDW'(TOUT - 1);
   localparam logic [6:0]     W_V     = 7'(W);

   typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} state_t;

   state_t         r_state;
   state_t         w_stateNext;
   logic           r_bS1, r_bS2, r_bS3;
   logic           r_lS1, r_lS2;
   logic           r_dS1, r_dS2;
   logic           r_wsPrev;
   logic [5:0]     r_cnt;
   logic [W-1:0]   r_sr;
   logic [W-1:0]   r_lbuf;
   logic           r_lvalid;
   logic [WDW-1:0] r_wdog;
   logic [W-1:0]   w_bitMask;
   logic [W-1:0]   w_word;
   logic           w_rise, w_wsEdge, w_expire, w_inWord, w_short;
   logic           w_latchL, w_emit, w_ferr, w_clrLvalid;

   assign w_rise   = r_bS2 & ~r_bS3;
   assign w_wsEdge = w_rise & (r_lS2 != r_wsPrev);
   assign w_expire = ~w_rise & (r_wdog == TOUT_M1);
   assign w_inWord = {1'b0, r_cnt} < W_V;
   assign w_short  = ({1'b0, r_cnt} + 7'd1) < W_V;
   assign locked   = (r_state != S_IDLE);

   // One-hot slot for the incoming bit; empty once the word is longer than W
   always_comb begin
      w_bitMask = '0;
      for (int i = 0; i < W; i++) begin
         w_bitMask[i] = w_inWord && (int'(r_cnt) == W - 1 - i);
      end
   end

   assign w_word = r_sr | (r_dS2 ? w_bitMask : '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_latchL    = 1'b0;
      w_emit      = 1'b0;
      w_ferr      = 1'b0;
      w_clrLvalid = w_expire;
      if (w_expire) begin
         w_stateNext = S_IDLE;
      end else if (w_wsEdge) begin
         case (r_state)
            S_IDLE:  w_stateNext = r_lS2 ? S_RIGHT : S_LEFT;
            S_LEFT: begin
               w_stateNext = S_RIGHT;
               w_latchL    = 1'b1;
               w_ferr      = w_short;
            end
            S_RIGHT: begin
               w_stateNext = S_LEFT;
               w_emit      = r_lvalid;
               w_ferr      = w_short;
               w_clrLvalid = 1'b1;
            end
            default: w_stateNext = S_IDLE;
         endcase
      end
   end

   // Watchdog expiry can only fire on a cycle without a rise, so rise always wins
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bS1     <= 1'b0;
         r_bS2     <= 1'b0;
         r_bS3     <= 1'b0;
         r_lS1     <= 1'b0;
         r_lS2     <= 1'b0;
         r_dS1     <= 1'b0;
         r_dS2     <= 1'b0;
         r_wsPrev  <= 1'b0;
         r_cnt     <= '0;
         r_sr      <= '0;
         r_lbuf    <= '0;
         r_lvalid  <= 1'b0;
         r_wdog    <= '0;
         snd_left  <= '0;
         snd_right <= '0;
         sample    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         r_bS1     <= i2s_bclk;
         r_bS2     <= r_bS1;
         r_bS3     <= r_bS2;
         r_lS1     <= i2s_lrclk;
         r_lS2     <= r_lS1;
         r_dS1     <= i2s_data;
         r_dS2     <= r_dS1;
         sample    <= w_emit;
         frame_err <= w_ferr;

         if (w_emit) begin
            snd_left  <= r_lbuf;
            snd_right <= w_word;
         end
         if (w_latchL) begin
            r_lbuf <= w_word;
         end

         if (w_clrLvalid) begin
            r_lvalid <= 1'b0;
         end else if (w_latchL) begin
            r_lvalid <= 1'b1;
         end

         if (w_rise) begin
            r_wdog <= '0;
         end else if (r_wdog != TOUT_V) begin
            r_wdog <= r_wdog + WDW'(1);
         end

         if (w_expire) begin
            r_cnt <= '0;
            r_sr  <= '0;
         end else if (w_wsEdge) begin
            r_cnt    <= '0;
            r_sr     <= '0;
            r_wsPrev <= r_lS2;
         end else if (w_rise) begin
            r_sr <= w_word;
            if (r_cnt != 6'd63) begin
               r_cnt <= r_cnt + 6'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_jtframe_i2s_rx.sv
// Bench for jtframe_i2s_rx: drives I2S slots, predicts pairs and frame errors
// from a word-level model, and checks both a TOUT=255 and a TOUT=8 receiver.
module tb_jtframe_i2s_rx;

   localparam int W = 16;
   localparam int M_IDLE  = 0;
   localparam int M_LEFT  = 1;
   localparam int M_RIGHT = 2;

   typedef struct packed {
      logic [W-1:0] l;
      logic [W-1:0] r;
   } pair_t;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         bclk  = 1'b0;
   logic         lrclk = 1'b0;
   logic         data  = 1'b0;
   logic [W-1:0] left0, right0, left1, right1;
   logic         sample0, ferr0, locked0;
   logic         sample1, ferr1, locked1;

   jtframe_i2s_rx #(.W(W), .TOUT(255)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i2s_bclk  (bclk),
      .i2s_lrclk (lrclk),
      .i2s_data  (data),
      .snd_left  (left0),
      .snd_right (right0),
      .sample    (sample0),
      .frame_err (ferr0),
      .locked    (locked0)
   );

   jtframe_i2s_rx #(.W(W), .TOUT(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .i2s_bclk  (bclk),
      .i2s_lrclk (lrclk),
      .i2s_data  (data),
      .snd_left  (left1),
      .snd_right (right1),
      .sample    (sample1),
      .frame_err (ferr1),
      .locked    (locked1)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int    checks = 0;
   int    errors = 0;
   pair_t sq0[$];
   pair_t sq1[$];
   bit    eq0[$];
   bit    eq1[$];
   pair_t mp0, mp1;

   int           mTout[2] = '{255, 8};
   int           mState[2];
   logic         mWsPrev[2];
   logic         mLvalid[2];
   logic [W-1:0] mLbuf[2];
   logic [W-1:0] mLastL[2];
   logic [W-1:0] mLastR[2];
   logic [31:0]  mBitVec[2];
   int           mBitCnt[2];
   int           lastRise = -100000;
   bit           watch8 = 1'b0;
   bit           drop8  = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mState[i]  = M_IDLE;
         mWsPrev[i] = 1'b0;
         mLvalid[i] = 1'b0;
         mLbuf[i]   = '0;
         mLastL[i]  = '0;
         mLastR[i]  = '0;
         mBitVec[i] = '0;
         mBitCnt[i] = 0;
      end
   endtask

   // Word-level view: a word is the list of bits seen since the last ws change,
   // first W of them MSB-aligned and zero padded
   task automatic modelSlot(input int i, input int interval, input logic ws, input logic d);
      logic [W-1:0] word;
      pair_t        p;
      if (interval > mTout[i]) begin
         mState[i]  = M_IDLE;
         mLvalid[i] = 1'b0;
         mBitCnt[i] = 0;
      end
      if (mBitCnt[i] < W) mBitVec[i][mBitCnt[i]] = d;
      mBitCnt[i]++;
      if (ws != mWsPrev[i]) begin
         word = '0;
         for (int k = 0; k < W; k++) begin
            if (k < mBitCnt[i]) word[W-1-k] = mBitVec[i][k];
         end
         if (mState[i] == M_IDLE) begin
            mState[i] = ws ? M_RIGHT : M_LEFT;
         end else if (mState[i] == M_LEFT) begin
            mLbuf[i]   = word;
            mLvalid[i] = 1'b1;
            if (mBitCnt[i] < W) begin
               if (i == 0) eq0.push_back(1'b1); else eq1.push_back(1'b1);
            end
            mState[i] = M_RIGHT;
         end else begin
            if (mBitCnt[i] < W) begin
               if (i == 0) eq0.push_back(1'b1); else eq1.push_back(1'b1);
            end
            if (mLvalid[i]) begin
               p.l = mLbuf[i];
               p.r = word;
               mLastL[i] = p.l;
               mLastR[i] = p.r;
               if (i == 0) sq0.push_back(p); else sq1.push_back(p);
            end
            mLvalid[i] = 1'b0;
            mState[i]  = M_LEFT;
         end
         mBitCnt[i] = 0;
         mWsPrev[i] = ws;
      end
   endtask

   task automatic sendSlot(input logic ws, input logic d, input int lo, input int hi);
      int iv;
      bclk  = 1'b0;
      lrclk = ws;
      data  = d;
      repeat (lo) @(negedge clk);
      bclk     = 1'b1;
      iv       = cyc - lastRise;
      lastRise = cyc;
      modelSlot(0, iv, ws, d);
      modelSlot(1, iv, ws, d);
      repeat (hi) @(negedge clk);
   endtask

   // LRCLK switches on the LSB slot of each word, one bit ahead of the next MSB
   task automatic applyStimulus(input int frames, input int nBits, input logic [31:0] lw,
                                input logic [31:0] rw, input int lo, input int hi, input bit rnd);
      logic [31:0] val;
      logic        wsCh;
      logic        ws;
      int          l, h;
      for (int f = 0; f < frames; f++) begin
         if (rnd) begin
            lw = $urandom;
            rw = $urandom;
         end
         for (int ch = 0; ch < 2; ch++) begin
            val  = (ch == 1) ? rw : lw;
            wsCh = (ch == 1);
            for (int j = 0; j < nBits; j++) begin
               ws = (j == nBits - 1) ? ~wsCh : wsCh;
               l  = rnd ? int'($urandom_range(6, 2)) : lo;
               h  = rnd ? int'($urandom_range(6, 2)) : hi;
               sendSlot(ws, val[nBits-1-j], l, h);
            end
         end
      end
   endtask

   // Scoreboard monitor: every strobe must match the oldest prediction
   always @(negedge clk) begin
      if (sample0 === 1'b1) begin
         if (sq0.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sample0: unexpected strobe L=%h R=%h, required none", left0, right0);
         end else begin
            mp0 = sq0.pop_front();
            checkOutput("snd_left0", 32'(left0), 32'(mp0.l));
            checkOutput("snd_right0", 32'(right0), 32'(mp0.r));
         end
      end
      if (ferr0 === 1'b1) begin
         checks++;
         if (eq0.size() == 0) begin
            errors++;
            $display("[TB] FAIL frame_err0: got unexpected strobe, required none");
         end else begin
            void'(eq0.pop_front());
         end
      end
      if (sample1 === 1'b1) begin
         if (sq1.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sample1: unexpected strobe L=%h R=%h, required none", left1, right1);
         end else begin
            mp1 = sq1.pop_front();
            checkOutput("snd_left1", 32'(left1), 32'(mp1.l));
            checkOutput("snd_right1", 32'(right1), 32'(mp1.r));
         end
      end
      if (ferr1 === 1'b1) begin
         checks++;
         if (eq1.size() == 0) begin
            errors++;
            $display("[TB] FAIL frame_err1: got unexpected strobe, required none");
         end else begin
            void'(eq1.pop_front());
         end
      end
      if (watch8 && locked1 !== 1'b1) drop8 = 1'b1;
   end

   initial begin
      modelReset();
      repeat (3) @(negedge clk);
      checkOutput("reset snd_left", 32'(left0), 32'h0);
      checkOutput("reset snd_right", 32'(right0), 32'h0);
      checkOutput("reset sample", 32'(sample0), 32'h0);
      checkOutput("reset frame_err", 32'(ferr0), 32'h0);
      checkOutput("reset locked", 32'(locked0), 32'h0);
      checkOutput("reset locked8", 32'(locked1), 32'h0);
      rst_n    = 1'b1;
      lastRise = cyc;

      $display("[TB] startup, 32-bit slots");
      sendSlot(1'b0, 1'b0, 8, 8);
      applyStimulus(4, 32, 32'h8001_0000, 32'h7FFE_0000, 8, 8, 1'b0);
      repeat (6) @(negedge clk);
      checkOutput("startup locked", 32'(locked0), 32'h1);
      checkOutput("startup left", 32'(left0), 32'h8001);
      checkOutput("startup right", 32'(right0), 32'h7FFE);

      $display("[TB] exact 16-bit words");
      applyStimulus(3, 16, 32'h1234, 32'hABCD, 4, 4, 1'b0);
      repeat (6) @(negedge clk);
      checkOutput("exact left", 32'(left0), 32'h1234);
      checkOutput("exact right", 32'(right0), 32'hABCD);

      $display("[TB] short 12-bit words");
      applyStimulus(3, 12, 32'hABC, 32'h123, 4, 4, 1'b0);
      repeat (6) @(negedge clk);
      checkOutput("short left", 32'(left0), 32'hABC0);
      checkOutput("short right", 32'(right0), 32'h1230);

      $display("[TB] bclk stall mid-word");
      for (int j = 0; j < 5; j++) sendSlot(1'b0, 1'($urandom_range(1, 0)), 4, 4);
      bclk = 1'b0;
      repeat (300) @(negedge clk);
      checkOutput("stall locked", 32'(locked0), 32'h0);
      checkOutput("stall locked8", 32'(locked1), 32'h0);
      checkOutput("stall left held", 32'(left0), 32'(mLastL[0]));
      checkOutput("stall right held", 32'(right0), 32'(mLastR[0]));
      applyStimulus(3, 16, 32'h5A5A, 32'hC3C3, 4, 4, 1'b0);
      repeat (6) @(negedge clk);
      checkOutput("resume left", 32'(left0), 32'h5A5A);
      checkOutput("resume right", 32'(right0), 32'hC3C3);

      $display("[TB] reset mid-left-word");
      applyStimulus(1, 16, 32'h1111, 32'h2222, 4, 4, 1'b0);
      for (int j = 0; j < 6; j++) sendSlot(1'b0, 1'b1, 4, 4);
      bclk = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midreset left", 32'(left0), 32'h0);
      checkOutput("midreset right", 32'(right0), 32'h0);
      checkOutput("midreset locked", 32'(locked0), 32'h0);
      checkOutput("midreset left8", 32'(left1), 32'h0);
      rst_n = 1'b1;
      modelReset();
      lastRise = cyc;
      applyStimulus(3, 16, 32'h3C3C, 32'h4D4D, 4, 4, 1'b0);
      repeat (6) @(negedge clk);
      checkOutput("postreset left", 32'(left0), 32'h3C3C);
      checkOutput("postreset right", 32'(right0), 32'h4D4D);

      $display("[TB] randomized words and timing");
      for (int s = 0; s < 12; s++) begin
         applyStimulus(1, int'($urandom_range(32, 8)), 32'h0, 32'h0, 0, 0, 1'b1);
      end

      $display("[TB] bclk period equal to watchdog limit");
      bclk = 1'b0;
      repeat (20) @(negedge clk);
      applyStimulus(1, 16, 32'h0F0F, 32'hF0F0, 4, 4, 1'b0);
      watch8 = 1'b1;
      applyStimulus(3, 16, 32'h1357, 32'h2468, 4, 4, 1'b0);
      watch8 = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("tout8 lock held", 32'(drop8), 32'h0);
      checkOutput("tout8 left", 32'(left1), 32'h1357);
      checkOutput("tout8 right", 32'(right1), 32'h2468);

      repeat (20) @(negedge clk);
      checkOutput("pairs pending0", 32'(sq0.size()), 32'h0);
      checkOutput("frame_err pending0", 32'(eq0.size()), 32'h0);
      checkOutput("pairs pending1", 32'(sq1.size()), 32'h0);
      checkOutput("frame_err pending1", 32'(eq1.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jtframe_i2s_rx.md
# jtframe_i2s_rx

I2S receiver that deserialises an external BCLK/LRCLK/DATA stream into parallel left/right signed samples in the system clock domain. It is the receive counterpart of the I2S DAC transmitter in the board top levels. It lets a core accept audio from an external codec or ADC, or loop back its own I2S output for verification. It oversamples the three I2S pins with `clk`, so the pins may be fully asynchronous to it.

## Interface
Parameters:
- `W`, 16: output sample width in bits, MSB-aligned; valid range 8..32.
- `TOUT`, 255: number of `clk` cycles without a BCLK rising edge before the receiver drops back to IDLE.

Ports:
- `clk` in 1: system clock. One clock; reset is synchronous and active-low.
- `rst_n` in 1: synchronous, active-low reset.
- `i2s_bclk` in 1: bit clock, asynchronous.
- `i2s_lrclk` in 1: word select; 0 selects left, 1 selects right. Asynchronous.
- `i2s_data` in 1: serial data, MSB first, asynchronous.
- `snd_left` out W: last complete left sample, two's complement.
- `snd_right` out W: last complete right sample, two's complement.
- `sample` out 1: one-cycle strobe when the L/R pair updates.
- `frame_err` out 1: one-cycle strobe when a latched word carried fewer than W bits.
- `locked` out 1: high while the receiver is in the LEFT or RIGHT state.

## Operation
- **Synchroniser:** each pin passes through two flops. A third flop on BCLK gives `rise = b_s2 & ~b_s3`. All logic below advances only on `rise`.
- **Capture on `rise`:** sample `d = data_s2` and `ws = lrclk_s2`, and compare `ws` with `ws_prev`, which is the ws value captured on the previous `rise`.
- **I2S one-bit delay:** the bit captured on the `rise` where `ws != ws_prev` is the LSB of the old word. The next `rise` carries the MSB of the new word.
- **Word assembly:** bit counter `cnt` (6 bits, saturates at 63) and shift register `sr[W-1:0]`.
  - When `cnt < W`, write the bit as `sr[W-1-cnt] <= d`. Bits at index W and above are discarded, which truncates long words.
  - On a word boundary, latch `sr`, including the boundary bit when `cnt < W`. Unwritten LSBs are 0, which pads short words.
  - Then clear `sr`, set `cnt <= 0`, and set `ws_prev <= ws`.
- **State machine, states IDLE / LEFT / RIGHT:**
  - IDLE: on the first ws edge, discard the partial word and go to LEFT if the new `ws` is 0, else RIGHT.
  - LEFT to RIGHT on a ws edge: latch the word into `lbuf` and set `lvalid <= 1`.
  - RIGHT to LEFT on a ws edge: latch the word. If `lvalid` is set, drive `snd_left <= lbuf` and `snd_right <= word`, and pulse `sample`. In both cases clear `lvalid`.
  - Any state to IDLE when the watchdog reaches TOUT. This also clears `lvalid`, `cnt` and `sr`.
- **Watchdog:** counter is cleared on every `rise` and saturates at TOUT.
- **`frame_err`:** pulses with any word latch outside IDLE where `cnt + 1 < W`, counting the boundary bit. The padded word is still used.
- **Simultaneous watchdog expiry and `rise`:** `rise` wins and the watchdog counter is cleared.

## Timing
- Reset values: `snd_left` = 0, `snd_right` = 0, `sample` = 0, `frame_err` = 0, `locked` = 0, state IDLE, `lvalid` = 0, all counters 0, synchroniser flops 0.
- BCLK high and low phases must each last at least 2 `clk` cycles; pins must be stable across 2 consecutive `clk` samples. DATA and LRCLK change on BCLK falling edges.
- `rise` is asserted in the 3rd `clk` cycle after the pin's BCLK rising edge.
- `snd_left`, `snd_right`, `sample` and `frame_err` are registered and become valid 1 `clk` after the boundary `rise`, i.e. 4 `clk` after the pin edge.
- `snd_*` hold their value between strobes. `sample` and `frame_err` are high for exactly 1 cycle.
- `locked` rises on the same cycle the state leaves IDLE. It falls on the cycle the watchdog expires or `rst_n` is sampled low.
- Reset mid-word discards everything. The next pair is produced no earlier than the second RIGHT-to-LEFT boundary after release.

## Test plan
- Startup: clk 48 MHz, BCLK 3.072 MHz, 32 BCLK per channel, L = 0x8001, R = 0x7FFE repeated.
  - The first partial frame gives no `sample`.
  - Every later frame gives one `sample` with `snd_left` = 0x8001, `snd_right` = 0x7FFE, and `frame_err` = 0.
- Exact 16-bit channels (16 BCLK per channel), L = 0x1234, R = 0xABCD: `sample` once per frame with those exact values and no `frame_err`.
- Short words (12 BCLK per channel), L bits 0xABC, R bits 0x123: `snd_left` = 0xABC0, `snd_right` = 0x1230, with `frame_err` pulsing twice per frame.
- BCLK held low for 300 `clk` mid-word: `locked` falls at TOUT and `snd_*` keep their old values. After BCLK resumes, the first new `sample` comes only after a full L/R pair.
- `rst_n` low for 1 cycle mid-left-word: all outputs go to 0 on the next edge. The next `sample` value comes only from complete words received after the reset.
- LRCLK edge on the same `clk` as a watchdog expiry (TOUT = 8, BCLK stretched to exactly 8 cycles): `rise` wins, `locked` stays high, and there is no spurious `frame_err`.
